// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if - bus bundle between the ALU sequencer and its environment.
//   command port : i_cmd_valid, i_cmd_fun, o_cmd_ready
//   regfile port : o_rf_rd_en, o_rf_addr, i_rf_rd_data, i_rf_rd_valid
//   ALU port     : o_alu_en, o_alu_fun, o_alu_a, o_alu_b, i_alu_res, i_alu_valid
//   TX byte port : o_tx_data, o_tx_valid, i_tx_ready
//   status       : o_busy, o_err
// Signal prefixes are from the sequencer's point of view.
// The slave modport is the sequencer; master is the surrounding system.
interface alu_ctrl_if #(
    parameter int FUN  = 4,
    parameter int BUSA = 8,
    parameter int BUSB = 8,
    parameter int BUSR = 16,
    parameter int ADDR = 4
);
    logic            i_cmd_valid;
    logic [FUN-1:0]  i_cmd_fun;
    logic            o_cmd_ready;
    logic            o_rf_rd_en;
    logic [ADDR-1:0] o_rf_addr;
    logic [BUSA-1:0] i_rf_rd_data;
    logic            i_rf_rd_valid;
    logic            o_alu_en;
    logic [FUN-1:0]  o_alu_fun;
    logic [BUSA-1:0] o_alu_a;
    logic [BUSB-1:0] o_alu_b;
    logic [BUSR-1:0] i_alu_res;
    logic            i_alu_valid;
    logic [7:0]      o_tx_data;
    logic            o_tx_valid;
    logic            i_tx_ready;
    logic            o_busy;
    logic            o_err;

    modport slave (
        input  i_cmd_valid, i_cmd_fun, i_rf_rd_data, i_rf_rd_valid,
               i_alu_res, i_alu_valid, i_tx_ready,
        output o_cmd_ready, o_rf_rd_en, o_rf_addr, o_alu_en, o_alu_fun,
               o_alu_a, o_alu_b, o_tx_data, o_tx_valid, o_busy, o_err
    );

    modport master (
        output i_cmd_valid, i_cmd_fun, i_rf_rd_data, i_rf_rd_valid,
               i_alu_res, i_alu_valid, i_tx_ready,
        input  o_cmd_ready, o_rf_rd_en, o_rf_addr, o_alu_en, o_alu_fun,
               o_alu_a, o_alu_b, o_tx_data, o_tx_valid, o_busy, o_err
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl - sequencer between system controller, register file and ALU.
// Per command: read A (addr 0) and B (addr 1) from the register file, fire
// the ALU for one cycle, capture the result, stream it LSB byte first on a
// valid/ready byte port, then return to idle. One command in flight.
//
// Ports:
//   i_clk     clock, rising edge
//   i_arst_n  asynchronous active-low reset
//   bus       alu_ctrl_if.slave (command, regfile, ALU, TX and status signals)
//
// Optional feature: ALU_DIV0_GUARD_EN. When defined, a divide (fun 3) with
// B==0 does not fire the ALU; the result is forced to all ones and o_err
// pulses for one cycle. When undefined the ALU is always fired and o_err=0.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for a command, o_cmd_ready=1
// RD_A  | register-file read strobe, address 0
// WT_A  | waiting for read data, latch operand A
// RD_B  | register-file read strobe, address 1
// WT_B  | waiting for read data, latch operand B
// EXEC  | ALU enable for one cycle, capture result
// SEND  | stream result bytes LSB first
module alu_ctrl #(
    parameter int FUN  = 4,
    parameter int BUSA = 8,
    parameter int BUSB = 8,
    parameter int BUSR = 16,
    parameter int ADDR = 4
) (
    input logic       i_clk,
    input logic       i_arst_n,
    alu_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] WT_A = 3'd2;
    localparam logic [2:0] RD_B = 3'd3;
    localparam logic [2:0] WT_B = 3'd4;
    localparam logic [2:0] EXEC = 3'd5;
    localparam logic [2:0] SEND = 3'd6;

    localparam int NBYTES = BUSR / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    logic [2:0]      state_q, state_d;
    logic [FUN-1:0]  fun_q, fun_d;
    logic [BUSA-1:0] a_q, a_d;
    logic [BUSB-1:0] b_q, b_d;
    logic [BUSR-1:0] res_q, res_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            div0;

`ifdef ALU_DIV0_GUARD_EN
    assign div0 = (fun_q == FUN'(3)) && (b_q == '0);
`else
    assign div0 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        fun_d   = fun_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    fun_d   = bus.i_cmd_fun;
                    state_d = RD_A;
                end
            end
            RD_A: state_d = WT_A;
            WT_A: begin
                if (bus.i_rf_rd_valid) begin
                    a_d     = bus.i_rf_rd_data;
                    state_d = RD_B;
                end
            end
            RD_B: state_d = WT_B;
            WT_B: begin
                if (bus.i_rf_rd_valid) begin
                    b_d     = BUSB'(bus.i_rf_rd_data);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (div0)
                    res_d = '1;
                else if (bus.i_alu_valid)
                    res_d = bus.i_alu_res;
                else
                    res_d = '0;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (bus.i_tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
            fun_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            fun_q   <= fun_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    // All control outputs decode from the registered state, so a reset
    // clears them immediately and nothing partial escapes afterwards.
    assign bus.o_cmd_ready = (state_q == IDLE);
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_rf_rd_en  = (state_q == RD_A) || (state_q == RD_B);
    assign bus.o_rf_addr   = ((state_q == RD_B) || (state_q == WT_B)) ? ADDR'(1) : '0;
    assign bus.o_alu_en    = (state_q == EXEC) && !div0;
    assign bus.o_err       = (state_q == EXEC) && div0;
    assign bus.o_alu_fun   = fun_q;
    assign bus.o_alu_a     = a_q;
    assign bus.o_alu_b     = b_q;
    assign bus.o_tx_valid  = (state_q == SEND);
    assign bus.o_tx_data   = bus.o_tx_valid ? res_q[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule
